// File: rtl/hyperbus_rd_downsizer.sv
// HyperBus read downsizer: splits PHY read words into narrow AXI R beats.
// Ports: trans_* burst descriptor, rx_* PHY read words, r_* AXI R beats, busy_o.
module hyperbus_rd_downsizer #(
    parameter  int unsigned DataWidth = 32,
    parameter  int unsigned LenWidth  = 8,
    localparam int unsigned AddrWidth = $clog2(DataWidth/8)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 trans_valid_i,
    output logic                 trans_ready_o,
    input  logic [AddrWidth-1:0] start_addr_i,
    input  logic [2:0]           size_i,
    input  logic [LenWidth-1:0]  len_i,
    input  logic                 rx_valid_i,
    output logic                 rx_ready_o,
    input  logic [DataWidth-1:0] rx_data_i,
    input  logic                 rx_last_i,
    input  logic                 rx_error_i,
    output logic                 r_valid_o,
    input  logic                 r_ready_i,
    output logic [DataWidth-1:0] r_data_o,
    output logic                 r_last_o,
    output logic                 r_error_o,
    output logic                 busy_o
);
    localparam int unsigned Bytes = DataWidth/8;
    localparam int unsigned IW    = AddrWidth + 1;
    localparam int unsigned CW    = ((LenWidth > IW) ? LenWidth : IW) + 1;

    typedef enum logic [1:0] {IDLE, FETCH, EMIT} state_e;

    state_e                state_q, state_d;
    logic [AddrWidth-1:0]  byte_idx_q, byte_idx_d;
    logic [2:0]            size_q, size_d;
    logic [LenWidth-1:0]   beats_left_q, beats_left_d;
    logic [DataWidth-1:0]  buf_data_q, buf_data_d;
    logic                  buf_err_q, buf_err_d;
    logic                  buf_last_q, buf_last_d;

    logic [IW-1:0]         step;
    logic [IW-1:0]         idx_sum;
    logic                  word_end;
    logic                  last_beat;
    logic                  consume;
    logic                  r_hs;
    logic                  rx_hs;
    logic [AddrWidth-1:0]  load_idx;
    logic [LenWidth-1:0]   load_left;
    logic [IW-1:0]         load_beats;
    logic                  premature;
    logic [2:0]            size_eff;
    logic [AddrWidth-1:0]  size_mask;
    logic [DataWidth-1:0]  lane_mask;

    // Oversized beats collapse to one full word per beat.
    assign size_eff  = (size_i > 3'(AddrWidth)) ? 3'(AddrWidth) : size_i;
    assign size_mask = AddrWidth'((IW'(1) << size_eff) - IW'(1));

    assign step      = IW'(1) << size_q;
    assign idx_sum   = {1'b0, byte_idx_q} + step;
    assign word_end  = idx_sum[AddrWidth];
    assign last_beat = (beats_left_q == '0) || (word_end && buf_last_q);
    assign consume   = word_end && !last_beat;
    assign r_hs      = (state_q == EMIT) && r_ready_i;

    // The next word may be taken in the same cycle the current one is drained.
    assign rx_ready_o = (state_q == FETCH) || (r_hs && consume);
    assign rx_hs      = rx_valid_i && rx_ready_o;

    // A word loaded while emitting starts at lane 0 with one beat fewer left.
    assign load_idx   = (state_q == EMIT) ? '0 : byte_idx_q;
    assign load_left  = (state_q == EMIT) ? beats_left_q - LenWidth'(1)
                                          : beats_left_q;
    assign load_beats = (IW'(Bytes) - {1'b0, load_idx}) >> size_q;
    // PHY ends the burst before the word holding the final expected beat.
    assign premature  = rx_last_i && (CW'(load_left) >= CW'(load_beats));

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < Bytes; i++) begin
            if (IW'(i) >= {1'b0, byte_idx_q} && IW'(i) < idx_sum) begin
                lane_mask[8*i +: 8] = 8'hFF;
            end
        end
    end

    assign trans_ready_o = (state_q == IDLE);
    assign busy_o        = (state_q != IDLE);
    assign r_valid_o     = (state_q == EMIT);
    assign r_data_o      = r_valid_o ? (buf_data_q & lane_mask) : '0;
    assign r_last_o      = r_valid_o && last_beat;
    assign r_error_o     = r_valid_o && buf_err_q;

    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        size_d       = size_q;
        beats_left_d = beats_left_q;
        buf_data_d   = buf_data_q;
        buf_err_d    = buf_err_q;
        buf_last_d   = buf_last_q;
        unique case (state_q)
            IDLE: begin
                if (trans_valid_i) begin
                    byte_idx_d   = start_addr_i & ~size_mask;
                    size_d       = size_eff;
                    beats_left_d = len_i;
                    state_d      = FETCH;
                end
            end
            FETCH: begin
                if (rx_valid_i) state_d = EMIT;
            end
            EMIT: begin
                if (r_ready_i) begin
                    byte_idx_d   = idx_sum[AddrWidth-1:0];
                    beats_left_d = beats_left_q - LenWidth'(1);
                    if (last_beat) begin
                        state_d = IDLE;
                    end else if (consume && !rx_valid_i) begin
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (rx_hs) begin
            buf_data_d = rx_data_i;
            buf_err_d  = rx_error_i || premature;
            buf_last_d = rx_last_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            byte_idx_q   <= '0;
            size_q       <= '0;
            beats_left_q <= '0;
            buf_data_q   <= '0;
            buf_err_q    <= 1'b0;
            buf_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            size_q       <= size_d;
            beats_left_q <= beats_left_d;
            buf_data_q   <= buf_data_d;
            buf_err_q    <= buf_err_d;
            buf_last_q   <= buf_last_d;
        end
    end
endmodule

// File: tb/tb_hyperbus_rd_downsizer.sv
// Bench for hyperbus_rd_downsizer: table of bursts with literal expected beats,
// scoreboard queue of beats, plus a mid-burst reset sequence.
module tb_hyperbus_rd_downsizer;
    localparam int DW = 32;
    localparam int LW = 8;
    localparam int AW = 2;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          trans_valid_i = 1'b0;
    logic          trans_ready_o;
    logic [AW-1:0] start_addr_i = '0;
    logic [2:0]    size_i = '0;
    logic [LW-1:0] len_i = '0;
    logic          rx_valid_i = 1'b0;
    logic          rx_ready_o;
    logic [DW-1:0] rx_data_i = '0;
    logic          rx_last_i = 1'b0;
    logic          rx_error_i = 1'b0;
    logic          r_valid_o;
    logic          r_ready_i = 1'b1;
    logic [DW-1:0] r_data_o;
    logic          r_last_o;
    logic          r_error_o;
    logic          busy_o;

    hyperbus_rd_downsizer #(.DataWidth(DW), .LenWidth(LW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .trans_valid_i(trans_valid_i), .trans_ready_o(trans_ready_o),
        .start_addr_i(start_addr_i), .size_i(size_i), .len_i(len_i),
        .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
        .rx_data_i(rx_data_i), .rx_last_i(rx_last_i), .rx_error_i(rx_error_i),
        .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_data_o(r_data_o),
        .r_last_o(r_last_o), .r_error_o(r_error_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [2:0]          size;
        logic [AW-1:0]       start;
        logic [LW-1:0]       len;
        int                  nw;
        logic [3:0][DW-1:0]  w;
        int                  last_w;
        int                  err_w;
        int                  nb;
        logic [3:0][DW-1:0]  e;
        logic [3:0]          e_err;
        bit                  stall;
        bit                  hold;
    } vec_t;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
        logic          e;
    } beat_t;

    vec_t  vt[8];
    beat_t exp_q[$];
    int    n_chk = 0;
    int    n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h", nm, act, req);
    endtask

    function automatic vec_t mk(
        input logic [2:0] size, input logic [AW-1:0] start,
        input logic [LW-1:0] len, input int nw,
        input logic [DW-1:0] w0, input logic [DW-1:0] w1,
        input logic [DW-1:0] w2, input logic [DW-1:0] w3,
        input int last_w, input int err_w, input int nb,
        input logic [DW-1:0] e0, input logic [DW-1:0] e1,
        input logic [DW-1:0] e2, input logic [DW-1:0] e3,
        input logic [3:0] e_err, input bit stall, input bit hold);
        vec_t v;
        v.size = size; v.start = start; v.len = len; v.nw = nw;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
        v.last_w = last_w; v.err_w = err_w; v.nb = nb;
        v.e[0] = e0; v.e[1] = e1; v.e[2] = e2; v.e[3] = e3;
        v.e_err = e_err; v.stall = stall; v.hold = hold;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int id);
        int    widx = 0;
        int    rxn = 0;
        int    bs = 0;
        int    cyc = 0;
        int    stall_left = 3;
        int    first_rx = -1;
        int    first_b = -1;
        int    last_b = -1;
        bit    done = 0;
        bit    hs_t, hs_rx, hs_r, was_stall;
        logic [DW+2:0] held;
        beat_t b;
        string tag;
        tag = $sformatf("v%0d", id);
        was_stall = 0;
        held = '0;
        for (int i = 0; i < v.nb; i++) begin
            b.d = v.e[i];
            b.l = (i == v.nb - 1);
            b.e = v.e_err[i];
            exp_q.push_back(b);
        end
        start_addr_i = v.start;
        size_i = v.size;
        len_i = v.len;
        trans_valid_i = 1'b1;
        rx_valid_i = 1'b0;
        r_ready_i = 1'b1;
        while (!done && cyc < 200) begin
            @(negedge clk_i);
            hs_t  = trans_valid_i && trans_ready_o;
            hs_rx = rx_valid_i && rx_ready_o;
            hs_r  = r_valid_o && r_ready_i;
            if (was_stall)
                chk({tag, "_stall_hold"},
                    64'({r_valid_o, r_data_o, r_last_o, r_error_o}), 64'(held));
            if (r_valid_o && !r_ready_i)
                chk({tag, "_stall_rxrdy"}, 64'(rx_ready_o), 64'(0));
            was_stall = r_valid_o && !r_ready_i;
            held = {r_valid_o, r_data_o, r_last_o, r_error_o};
            if (hs_rx) begin
                rxn++;
                if (first_rx < 0) first_rx = cyc;
            end
            if (hs_r) begin
                if (exp_q.size() == 0) begin
                    chk({tag, "_extra_beat"}, 64'(r_data_o), 64'(0));
                end else begin
                    b = exp_q.pop_front();
                    chk($sformatf("%s_beat%0d", tag, bs),
                        64'({r_data_o, r_last_o, r_error_o}), 64'(b));
                end
                if (first_b < 0) first_b = cyc;
                last_b = cyc;
                bs++;
                if (r_last_o) done = 1;
            end
            @(posedge clk_i);
            #1;
            cyc++;
            if (hs_t) trans_valid_i = 1'b0;
            if (hs_rx) widx++;
            if (!(rx_valid_i && !hs_rx)) begin
                rx_valid_i = (widx < v.nw) &&
                             (v.hold || $urandom_range(0, 3) != 0);
                rx_data_i  = (widx < v.nw) ? v.w[widx] : '0;
                rx_last_i  = (widx == v.last_w);
                rx_error_i = (widx == v.err_w);
            end
            if (v.stall && bs == 1 && stall_left > 0) begin
                r_ready_i = 1'b0;
                stall_left--;
            end else begin
                r_ready_i = v.hold || ($urandom_range(0, 4) != 0);
            end
        end
        chk({tag, "_done"}, 64'(done), 64'(1));
        chk({tag, "_rx_count"}, 64'(rxn), 64'(v.nw));
        chk({tag, "_beats_left"}, 64'(exp_q.size()), 64'(0));
        if (v.hold) begin
            chk({tag, "_latency"}, 64'(first_b - first_rx), 64'(1));
            chk({tag, "_b2b"}, 64'(last_b - first_b), 64'(v.nb - 1));
        end
        exp_q.delete();
        rx_valid_i = 1'b0;
        r_ready_i = 1'b1;
        @(negedge clk_i);
        chk({tag, "_idle"}, 64'({busy_o, trans_ready_o, rx_ready_o, r_valid_o}),
            64'(4'b0100));
        @(posedge clk_i);
        #1;
    endtask

    task automatic reset_mid_burst();
        int cyc = 0;
        bit got = 0;
        bit hs_t, hs_rx;
        start_addr_i = '0;
        size_i = 3'd0;
        len_i = 8'd3;
        trans_valid_i = 1'b1;
        rx_data_i = 32'h44332211;
        rx_last_i = 1'b0;
        rx_error_i = 1'b0;
        rx_valid_i = 1'b1;
        r_ready_i = 1'b1;
        while (!got && cyc < 50) begin
            @(negedge clk_i);
            hs_t  = trans_valid_i && trans_ready_o;
            hs_rx = rx_valid_i && rx_ready_o;
            got   = r_valid_o && r_ready_i;
            @(posedge clk_i);
            #1;
            cyc++;
            if (hs_t) trans_valid_i = 1'b0;
            if (hs_rx) rx_valid_i = 1'b0;
        end
        chk("rst_beat1_seen", 64'(got), 64'(1));
        r_ready_i = 1'b0;
        @(negedge clk_i);
        chk("rst_pre_beat2", 64'({r_valid_o, r_data_o}), 64'({1'b1, 32'h00002200}));
        rst_ni = 1'b0;
        #1;
        chk("rst_mid_outs",
            64'({trans_ready_o, rx_ready_o, r_valid_o, r_last_o, r_error_o,
                 busy_o, r_data_o}), 64'({6'b100000, 32'h0}));
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        r_ready_i = 1'b1;
    endtask

    initial begin
        vt[0] = mk(3'd0, 2'd1, 8'd2, 1,
                   32'hDDCCBBAA, 32'h0, 32'h0, 32'h0, -1, -1, 3,
                   32'h0000BB00, 32'h00CC0000, 32'hDD000000, 32'h0,
                   4'b0000, 0, 0);
        vt[1] = mk(3'd1, 2'd3, 8'd3, 3,
                   32'h22221111, 32'h44443333, 32'h66665555, 32'h0, -1, -1, 4,
                   32'h22220000, 32'h00003333, 32'h44440000, 32'h00005555,
                   4'b0000, 1, 0);
        vt[2] = mk(3'd2, 2'd0, 8'd3, 4,
                   32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3,
                   -1, -1, 4,
                   32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3,
                   4'b0000, 0, 1);
        vt[3] = mk(3'd0, 2'd0, 8'd7, 1,
                   32'hDDCCBBAA, 32'h0, 32'h0, 32'h0, 0, -1, 4,
                   32'h000000AA, 32'h0000BB00, 32'h00CC0000, 32'hDD000000,
                   4'b1111, 0, 0);
        vt[4] = mk(3'd7, 2'd2, 8'd1, 2,
                   32'h11223344, 32'h55667788, 32'h0, 32'h0, -1, -1, 2,
                   32'h11223344, 32'h55667788, 32'h0, 32'h0,
                   4'b0000, 0, 0);
        vt[5] = mk(3'd1, 2'd0, 8'd1, 1,
                   32'hBEEF1234, 32'h0, 32'h0, 32'h0, -1, 0, 2,
                   32'h00001234, 32'hBEEF0000, 32'h0, 32'h0,
                   4'b0011, 0, 0);
        vt[6] = mk(3'd0, 2'd2, 8'd1, 1,
                   32'h87654321, 32'h0, 32'h0, 32'h0, 0, -1, 2,
                   32'h00650000, 32'h87000000, 32'h0, 32'h0,
                   4'b0000, 1, 0);
        vt[7] = mk(3'd1, 2'd1, 8'd0, 1,
                   32'h12345678, 32'h0, 32'h0, 32'h0, -1, -1, 1,
                   32'h00005678, 32'h0, 32'h0, 32'h0,
                   4'b0000, 0, 0);

        #2;
        chk("reset_outs",
            64'({trans_ready_o, rx_ready_o, r_valid_o, r_last_o, r_error_o,
                 busy_o, r_data_o}), 64'({6'b100000, 32'h0}));
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("idle_rx_ready", 64'({rx_ready_o, trans_ready_o}), 64'(2'b01));
        @(posedge clk_i);
        #1;

        for (int i = 0; i < 8; i++) run_vec(vt[i], i);

        reset_mid_burst();
        run_vec(vt[0], 8);
        run_vec(vt[1], 9);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
